// File: rtl/pipeline_pkg.sv
// Shared definitions for the IF/ID instruction queue.
//   XLEN / ILEN : default PC and instruction widths
//   NOP_INSTR   : instruction presented to ID when no entry is valid (addi x0, x0, 0)
//   if_id_entry_t : one buffered {pc, instr} pair
package pipeline_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/pipeline_if_id_queue_if.sv
// Handshake bundle between the IF stage, the IF/ID queue and the ID stage.
//   master : the pipeline side (IF producer, ID consumer, EX flush source)
//   slave  : the queue itself
// Signals:
//   flush                                  branch taken; drop everything buffered
//   in_valid / pc_IF / instruction_IF      fetched instruction from IF
//   in_ready                               queue can accept (IF stall = !in_ready)
//   valid_ID / pc_ID / instruction_ID      head entry presented to ID
//   id_ready                               ID consumes the head this cycle
//   count                                  number of buffered entries
interface pipeline_if_id_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = pipeline_pkg::XLEN,
    parameter int ILEN  = pipeline_pkg::ILEN
);
    import pipeline_pkg::*;

    logic                     flush;
    logic                     in_valid;
    logic [XLEN-1:0]          pc_IF;
    logic [ILEN-1:0]          instruction_IF;
    logic                     in_ready;
    logic                     valid_ID;
    logic [XLEN-1:0]          pc_ID;
    logic [ILEN-1:0]          instruction_ID;
    logic                     id_ready;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, in_valid, pc_IF, instruction_IF, id_ready,
        input  in_ready, valid_ID, pc_ID, instruction_ID, count
    );

    modport slave (
        input  flush, in_valid, pc_IF, instruction_IF, id_ready,
        output in_ready, valid_ID, pc_ID, instruction_ID, count
    );

endinterface

// File: rtl/pipeline_fifo_mem.sv
// DEPTH x WIDTH storage for the IF/ID queue.
// Registered write port, combinational (asynchronous) read port.
// Contents are never reset; the owner gates the read data with its own valid.
//   clk      clock
//   wr_en    write entry[wr_addr] with wr_data on the rising edge
//   wr_addr  write index
//   wr_data  write data
//   rd_addr  read index
//   rd_data  entry[rd_addr], combinational
module pipeline_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    import pipeline_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipeline_if_id_queue.sv
// Instruction queue between IF and ID.
// Buffers {pc, instruction} pairs so IF keeps fetching while ID stalls, drops
// every buffered (wrong-path) entry on flush, and presents the oldest entry to
// ID with a valid/ready handshake. in_ready depends on the occupancy only, so
// a full queue never passes a push through even when ID pops that cycle.
// Ports:
//   clk    clock
//   reset  synchronous, active-low
//   bus    queue side (slave modport) of pipeline_if_id_queue_if
module pipeline_if_id_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = pipeline_pkg::XLEN,
    parameter int ILEN  = pipeline_pkg::ILEN
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_if_id_queue_if.slave  bus
);
    import pipeline_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = XLEN + ILEN;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pipeline_if_id_queue: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             in_ready;
    logic             head_valid;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head_entry;

    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign head_valid = (count_q != '0);
    assign push       = bus.in_valid && in_ready;
    assign pop        = head_valid && bus.id_ready;

    // Flush and reset both discard the instruction presented this cycle, so
    // the storage write is suppressed along with the pointer update.
    pipeline_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push && reset && !bus.flush),
        .wr_addr (wr_ptr),
        .wr_data ({bus.pc_IF, bus.instruction_IF}),
        .rd_addr (rd_ptr),
        .rd_data (head_entry)
    );

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!reset || bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Stale storage is never exposed: an empty queue shows pc 0 and a NOP.
    assign bus.in_ready       = in_ready;
    assign bus.valid_ID       = head_valid;
    assign bus.pc_ID          = head_valid ? head_entry[ENT_W-1:ILEN] : '0;
    assign bus.instruction_ID = head_valid ? head_entry[ILEN-1:0]     : NOP_INSTR;
    assign bus.count          = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        count_q <= CNT_W'(DEPTH));

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        (count_q == CNT_W'(DEPTH)) |-> !push);

endmodule

// File: tb/tb_pipeline_if_id_queue.sv
module tb_pipeline_if_id_queue;
    import pipeline_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    pipeline_if_id_queue_if #(.DEPTH(DEPTH), .XLEN(64), .ILEN(32)) bus ();

    pipeline_if_id_queue #(.DEPTH(DEPTH), .XLEN(64), .ILEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // addi x1, x0, pc[11:0] -- a distinct, recognisable instruction per PC.
    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return {pc[11:0], 20'h00093};
    endfunction

    task automatic present(input logic v, input logic [63:0] pc);
        bus.in_valid       = v;
        bus.pc_IF          = pc;
        bus.instruction_IF = instr_of(pc);
    endtask

    task automatic push_one(input logic [63:0] pc);
        present(1'b1, pc);
        tick();
        present(1'b0, 64'h0);
    endtask

    task automatic chk_head(input string tag, input logic [63:0] pc);
        chk({tag, "_valid"}, 64'(bus.valid_ID), 64'd1);
        chk({tag, "_pc"},    bus.pc_ID,          pc);
        chk({tag, "_instr"}, 64'(bus.instruction_ID), 64'(instr_of(pc)));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"},    64'(bus.valid_ID),       64'd0);
        chk({tag, "_pc"},       bus.pc_ID,               64'h0);
        chk({tag, "_instr"},    64'(bus.instruction_ID), 64'h0000_0013);
        chk({tag, "_count"},    64'(bus.count),          64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready),       64'd1);
    endtask

    initial begin
        reset        = 1'b0;
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        present(1'b1, 64'h40);

        // Reset held for two edges while IF presents an instruction.
        tick();
        tick();
        chk_empty("reset");
        reset = 1'b1;
        present(1'b0, 64'h0);
        tick();
        chk_empty("reset_idle");

        // Single-entry latency: pushed at edge N, visible after edge N.
        bus.id_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.pc_IF = 64'h0;
        bus.instruction_IF = 32'h0050_0093;
        tick();
        present(1'b0, 64'h0);
        chk("lat_valid", 64'(bus.valid_ID), 64'd1);
        chk("lat_pc",    bus.pc_ID,         64'h0);
        chk("lat_instr", 64'(bus.instruction_ID), 64'h0050_0093);
        chk("lat_count", 64'(bus.count), 64'd1);
        tick();
        chk("lat_drain_count", 64'(bus.count), 64'd0);
        chk("lat_drain_valid", 64'(bus.valid_ID), 64'd0);

        // Fill to full with ID stalled.
        bus.id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_one(64'(4 * i));
        end
        chk("full_count",    64'(bus.count), 64'd4);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk_head("full_head", 64'h0);

        // Fifth push is refused.
        present(1'b1, 64'h10);
        tick();
        chk("full_refuse_count", 64'(bus.count), 64'd4);
        chk("full_refuse_head",  bus.pc_ID, 64'h0);

        // ID resumes; 0x10 held on the bus is taken once a slot is free.
        bus.id_ready = 1'b1;
        tick();
        chk("pop1_count",    64'(bus.count), 64'd3);
        chk("pop1_in_ready", 64'(bus.in_ready), 64'd1);
        chk_head("pop1", 64'h4);
        tick();
        present(1'b0, 64'h0);
        chk("pop2_count", 64'(bus.count), 64'd3);
        chk_head("pop2", 64'h8);
        tick();
        chk_head("pop3", 64'hC);
        tick();
        chk_head("pop4", 64'h10);
        chk("pop4_count", 64'(bus.count), 64'd1);
        tick();
        chk("pop5_count", 64'(bus.count), 64'd0);

        // Steady push+pop at count 2, wrapping both pointers.
        bus.id_ready = 1'b0;
        push_one(64'h20);
        push_one(64'h24);
        chk("pp_start_count", 64'(bus.count), 64'd2);
        bus.id_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            present(1'b1, 64'(32'h24 + 4 * k));
            tick();
            chk($sformatf("pp%0d_count", k), 64'(bus.count), 64'd2);
            chk($sformatf("pp%0d_pc", k), bus.pc_ID, 64'(32'h20 + 4 * k));
        end
        present(1'b0, 64'h0);
        chk_head("pp_tail", 64'h38);
        tick();
        chk_head("pp_drain", 64'h3C);
        tick();
        chk("pp_empty_count", 64'(bus.count), 64'd0);

        // Flush at count 3 drops everything, including the concurrent push.
        bus.id_ready = 1'b0;
        push_one(64'h40);
        push_one(64'h44);
        push_one(64'h48);
        chk("fl_pre_count", 64'(bus.count), 64'd3);
        bus.flush = 1'b1;
        bus.id_ready = 1'b1;
        present(1'b1, 64'h100);
        tick();
        bus.flush = 1'b0;
        bus.id_ready = 1'b0;
        present(1'b1, 64'h200);
        chk_empty("fl_post");
        tick();
        present(1'b0, 64'h0);
        chk("fl_target_count", 64'(bus.count), 64'd1);
        chk_head("fl_target", 64'h200);
        bus.id_ready = 1'b1;
        tick();
        chk("fl_drain_count", 64'(bus.count), 64'd0);

        // Reset pulse mid-operation loses all entries.
        bus.id_ready = 1'b0;
        push_one(64'h300);
        push_one(64'h304);
        push_one(64'h308);
        chk("rst_pre_count", 64'(bus.count), 64'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_empty("rst_mid");
        push_one(64'h400);
        push_one(64'h404);
        chk("rst_after_count", 64'(bus.count), 64'd2);
        chk_head("rst_after", 64'h400);
        bus.id_ready = 1'b1;
        tick();
        chk_head("rst_after_pop", 64'h404);
        tick();
        chk("rst_after_empty", 64'(bus.count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_if_id_queue.md
Name: pipeline_if_id_queue

Overview:
- Instruction queue between the IF stage and the ID stage of the 5-stage CPU.
- Buffers {pc, instruction} pairs so IF can keep fetching while ID is stalled.
- Discards all buffered (wrong-path) instructions on a branch/jump flush.
- Presents the oldest entry to ID with a valid/ready handshake; its in_ready output is inverted to drive the IF stall input.

Parameters:
DEPTH, 4, number of entries; power of 2, minimum 2
XLEN, 64, PC width
ILEN, 32, instruction width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-low reset
flush  input  1  branch_taken from EX; discards all entries
in_valid  input  1  IF presents a fetched instruction this cycle
pc_IF  input  XLEN  PC of the fetched instruction
instruction_IF  input  ILEN  fetched instruction
in_ready  output  1  queue can accept; IF stall = !in_ready
valid_ID  output  1  head entry valid for ID
pc_ID  output  XLEN  PC of head entry
instruction_ID  output  ILEN  head instruction; NOP when invalid
id_ready  input  1  ID consumes head this cycle (low = ID stall)
count  output  $clog2(DEPTH)+1  number of buffered entries

Interface rules:
- One clock, clk.
- reset is synchronous and active-low: sampled only on the rising edge of clk; when low, the queue resets.

Behaviour:
- Storage: DEPTH-entry circular buffer with wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0) and count register.
- push = in_valid && in_ready. pop = valid_ID && id_ready.
- in_ready = (count != DEPTH). It is combinational from count only, never from id_ready; no pass-through when full.
- valid_ID = (count != 0).
- Head outputs are combinational reads of entry[rd_ptr], gated:
  - Invalid: pc_ID = 0 and instruction_ID = NOP (32'h0000_0013).
  - Valid: pc_ID and instruction_ID are the stored values.
- Latency: an entry pushed at edge N is visible at the outputs after edge N, i.e. one cycle minimum IF-to-ID.
- Per clock edge, in priority order:
  1. reset low: wr_ptr = rd_ptr = count = 0. Storage contents are not reset (outputs are gated).
  2. flush high: wr_ptr = rd_ptr = count = 0. Concurrent push and pop are ignored, so the instruction presented in the flush cycle is dropped (it is wrong-path).
  3. push only: write entry[wr_ptr], wr_ptr+1, count+1.
  4. pop only: rd_ptr+1, count-1.
  5. push and pop together (only possible when 0 < count < DEPTH): write and advance both pointers; count unchanged.
  6. neither: hold all state.
- Full: in_ready = 0. A pop at full frees a slot the following cycle.
- Empty: pop is impossible (valid_ID = 0). A push into an empty queue appears at the head the next cycle.
- Reset mid-operation: all entries are lost. Outputs read empty/NOP after the reset edge; in_ready = 1.
- After flush: in_ready = 1 in the following cycle, so the IF branch-target fetch is accepted immediately.
- Reset values: in_ready = 1, valid_ID = 0, pc_ID = 0, instruction_ID = 32'h0000_0013, count = 0.
- Assertions:
  - count <= DEPTH.
  - No push when count == DEPTH.
  - DEPTH is a power of 2.

Decomposition:
- Shared package pipeline_pkg holds:
  - XLEN and ILEN constants.
  - NOP_INSTR = 32'h0000_0013.
  - if_id_entry_t typedef {pc[XLEN-1:0], instr[ILEN-1:0]}.
- One sub-module, pipeline_fifo_mem: DEPTH x entry storage with a registered write port and combinational read port.
- Pointer, count and flush control stay in the top module.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with in_valid = 1 -> valid_ID = 0, instruction_ID = 0x00000013, pc_ID = 0, count = 0, in_ready = 1.
- Latency: push pc = 0x0, instr = 0x00500093 with id_ready = 1 -> next cycle valid_ID = 1, pc_ID = 0x0, instr = 0x00500093; following cycle count = 0.
- Fill/full: id_ready = 0, push pc 0x0, 0x4, 0x8, 0xC -> count = 4, in_ready = 0. A 5th push at pc 0x10 is not accepted. Raise id_ready -> pops come out in order 0x0, 0x4, 0x8, 0xC; 0x10 is accepted once in_ready returns to 1.
- Simultaneous push/pop at count = 2 for 6 cycles -> count stays 2, pointers wrap past 3, PCs are output in strict order.
- Flush: count = 3 with flush = 1, in_valid = 1, pc_IF = 0x100 in the same cycle -> next cycle count = 0, valid_ID = 0, and 0x100 is absent. Push of 0x200 the next cycle is accepted and appears at the head one cycle later.
- Reset mid-operation: count = 3, reset pulsed low for one cycle -> count = 0 and NOP output. Subsequent pushes behave normally starting from pointer 0.
